// File: rtl/swi_pkg.sv
// swi_pkg: shared widths, blank display code and lowest-set-bit encoder for the switch debouncer
package swi_pkg;
  localparam int SWI_MAX_WIDTH = 16;
  localparam int SWI_IDX_W = 5;
  localparam logic [SWI_IDX_W-1:0] SWI_NO_SWITCH = 5'd20;
  function automatic logic [SWI_IDX_W-1:0] lowest_set_idx(input logic [SWI_MAX_WIDTH-1:0] v);
    lowest_set_idx = SWI_NO_SWITCH;
    for (int i = SWI_MAX_WIDTH - 1; i >= 0; i--) if (v[i]) lowest_set_idx = SWI_IDX_W'(i);
  endfunction
endpackage

// File: rtl/swi_debounce_bit.sv
// swi_debounce_bit: two-flop synchronizer, stability counter, debounced state and edge pulses for one switch
module swi_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_i,
  output logic state_o,
  output logic state_d_o,
  output logic rise_o,
  output logic fall_o
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic s1_q, s2_q, state_q, state_d, rise_q, fall_q, accept;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // any return to equality drops the whole count
  always_comb begin
    accept = (s2_q != state_q) && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
    state_d = accept ? s2_q : state_q;
    cnt_d = (s2_q == state_q || accept) ? '0 : cnt_q + CNT_W'(1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {s1_q, s2_q, state_q, rise_q, fall_q} <= '0;
      cnt_q <= '0;
    end else begin
      s1_q <= sw_i;
      s2_q <= s1_q;
      state_q <= state_d;
      cnt_q <= cnt_d;
      rise_q <= accept & s2_q;
      fall_q <= accept & ~s2_q;
    end
  end
  assign state_o = state_q;
  assign state_d_o = state_d;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
endmodule

// File: rtl/swi_debounce.sv
// swi_debounce: debounced slide switches with edge pulses and lowest-active index (20 = blank digit).
// Defining SWI_STICKY_EN adds sw_ack/sw_pending sticky event flags.
module swi_debounce
  import swi_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef SWI_STICKY_EN
  input  logic [WIDTH-1:0]     sw_ack,
  output logic [WIDTH-1:0]     sw_pending,
`endif
  input  logic [WIDTH-1:0]     stswi,
  output logic [WIDTH-1:0]     sw_state,
  output logic [WIDTH-1:0]     sw_rise,
  output logic [WIDTH-1:0]     sw_fall,
  output logic                 sw_change,
  output logic [SWI_IDX_W-1:0] sw_index
);
  logic [WIDTH-1:0] state_d;
  logic [SWI_MAX_WIDTH-1:0] state_ext;
  logic [SWI_IDX_W-1:0] idx_q;
  genvar i;
  for (i = 0; i < WIDTH; i++) begin : g_bit
    swi_debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bit (
      .clk(clk), .rst_n(rst_n), .sw_i(stswi[i]), .state_o(sw_state[i]),
      .state_d_o(state_d[i]), .rise_o(sw_rise[i]), .fall_o(sw_fall[i])
    );
  end
  // encode the next state so the index lands in the same cycle as sw_state
  always_comb begin
    state_ext = '0;
    state_ext[WIDTH-1:0] = state_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idx_q <= SWI_NO_SWITCH;
    else idx_q <= lowest_set_idx(state_ext);
  end
  assign sw_index = idx_q;
  assign sw_change = |{sw_rise, sw_fall};
`ifdef SWI_STICKY_EN
  logic [WIDTH-1:0] pending_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else pending_q <= sw_rise | sw_fall | (pending_q & ~sw_ack);
  end
  assign sw_pending = pending_q;
`endif
endmodule

// File: tb/tb_swi_debounce.sv
// tb_swi_debounce: scenario tasks plus a sliding-window reference model for the switch debouncer
module tb_swi_debounce;
  localparam int D = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [15:0] stswi = '0, ack = '0;
  logic [15:0] sw_state, sw_rise, sw_fall, pend;
  logic sw_change;
  logic [4:0] sw_index;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  swi_debounce #(.WIDTH(16), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef SWI_STICKY_EN
    .sw_ack(ack), .sw_pending(pend),
`endif
    .stswi(stswi), .sw_state(sw_state), .sw_rise(sw_rise), .sw_fall(sw_fall),
    .sw_change(sw_change), .sw_index(sw_index)
  );
`ifndef SWI_STICKY_EN
  assign pend = '0;
`endif

  // Model: a bit is accepted once the synchronized input (raw input two edges old)
  // has differed from the debounced state in each of the last D samples.
  logic [15:0] hist [0:D];
  logic [15:0] m_state, m_rise, m_fall, m_pend;
  logic [4:0] m_idx;
  always @(posedge clk or negedge rst_n) begin
    automatic logic [15:0] acc, ns;
    if (!rst_n) begin
      for (int j = 0; j <= D; j++) hist[j] <= '0;
      m_state <= '0; m_rise <= '0; m_fall <= '0; m_pend <= '0; m_idx <= 5'd20;
    end else begin
      acc = '1;
      for (int j = 1; j <= D; j++) acc = acc & (hist[j] ^ m_state);
      ns = m_state ^ acc;
      hist[0] <= stswi;
      for (int j = 1; j <= D; j++) hist[j] <= hist[j-1];
      m_state <= ns;
      m_rise <= acc & ~m_state;
      m_fall <= acc & m_state;
      m_idx <= (ns == 0) ? 5'd20 : 5'($clog2(ns & -ns));
      m_pend <= m_rise | m_fall | (m_pend & ~ack);
    end
  end

  logic [69:0] obs_all, exp_all;
  assign obs_all = {pend, sw_state, sw_rise, sw_fall, sw_change, sw_index};
`ifdef SWI_STICKY_EN
  assign exp_all = {m_pend, m_state, m_rise, m_fall, |{m_rise, m_fall}, m_idx};
`else
  assign exp_all = {16'h0, m_state, m_rise, m_fall, |{m_rise, m_fall}, m_idx};
`endif

  task automatic test_reset;
    logic [15:0] es, er;
    rst_n = 1'b0; stswi = 16'h0021; ack = '0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({sw_state, sw_rise, sw_fall, sw_change, sw_index} !== {48'h0, 1'b0, 5'd20}) begin
      n_fail++; $display("FAIL reset_vals: got %h want %h", {sw_state, sw_rise, sw_fall, sw_change, sw_index}, {48'h0, 1'b0, 5'd20});
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      es = (e >= 6) ? 16'h0021 : 16'h0;
      er = (e == 6) ? 16'h0021 : 16'h0;
      n_chk++;
      if ({sw_state, sw_rise, sw_change, sw_index} !== {es, er, e == 6, (e >= 6) ? 5'd0 : 5'd20}) begin
        n_fail++; $display("FAIL reset_accept edge %0d: got %h/%h/%b/%0d want %h/%h", e, sw_state, sw_rise, sw_change, sw_index, es, er);
      end
      n_chk++;
      if (obs_all !== exp_all) begin n_fail++; $display("FAIL reset_model edge %0d: got %h want %h", e, obs_all, exp_all); end
    end
  endtask

  task automatic test_glitch;
    stswi = 16'h0;
    repeat (10) @(negedge clk);
    for (int c = 0; c < 14; c++) begin
      stswi = (c < 3) ? 16'h0008 : 16'h0;
      @(negedge clk);
      n_chk++;
      if ({sw_state, sw_rise, sw_change} !== 33'h0) begin
        n_fail++; $display("FAIL glitch cycle %0d: got %h/%h/%b want 0", c, sw_state, sw_rise, sw_change);
      end
      n_chk++;
      if (obs_all !== exp_all) begin n_fail++; $display("FAIL glitch_model: got %h want %h", obs_all, exp_all); end
    end
  endtask

  task automatic test_step;
    int hit;
    for (int ph = 0; ph < 2; ph++) begin
      stswi = (ph == 0) ? 16'h0008 : 16'h0;
      hit = 0;
      for (int e = 1; e <= 10; e++) begin
        @(negedge clk);
        if (hit == 0 && sw_state[3] == (ph == 0)) begin
          hit = e;
          n_chk++;
          if ({sw_rise, sw_fall, sw_change, sw_index} !== ((ph == 0) ? {16'h0008, 16'h0, 1'b1, 5'd3} : {16'h0, 16'h0008, 1'b1, 5'd20})) begin
            n_fail++; $display("FAIL step_pulse ph %0d: got %h/%h/%b/%0d", ph, sw_rise, sw_fall, sw_change, sw_index);
          end
        end
        n_chk++;
        if (obs_all !== exp_all) begin n_fail++; $display("FAIL step_model: got %h want %h", obs_all, exp_all); end
      end
      n_chk++;
      if (hit != 6) begin n_fail++; $display("FAIL step_latency ph %0d: got %0d want 6", ph, hit); end
    end
  endtask

  task automatic test_multi;
    int nchg;
    stswi = 16'h0006;
    repeat (10) @(negedge clk);
    n_chk++;
    if (sw_index !== 5'd1) begin n_fail++; $display("FAIL multi_idx_before: got %0d want 1", sw_index); end
    stswi = 16'h0009;
    nchg = 0;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      if (sw_change) begin
        nchg++;
        n_chk++;
        if ({sw_rise, sw_fall, sw_index} !== {16'h0009, 16'h0006, 5'd0}) begin
          n_fail++; $display("FAIL multi_pulse: got %h/%h/%0d want 0009/0006/0", sw_rise, sw_fall, sw_index);
        end
      end
      n_chk++;
      if (obs_all !== exp_all) begin n_fail++; $display("FAIL multi_model: got %h want %h", obs_all, exp_all); end
    end
    n_chk++;
    if (nchg != 1) begin n_fail++; $display("FAIL multi_change_count: got %0d want 1", nchg); end
  endtask

  task automatic test_reset_mid;
    int hit;
    stswi = 16'h0001;
    repeat (10) @(negedge clk);
    stswi = 16'h0021;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({sw_state, sw_rise, sw_fall, sw_change, sw_index} !== {48'h0, 1'b0, 5'd20}) begin
      n_fail++; $display("FAIL async_reset: got %h/%0d want 0/20", sw_state, sw_index);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hit = 0;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      if (hit == 0 && sw_state != 0) begin
        hit = e;
        n_chk++;
        if ({sw_state, sw_rise, sw_index} !== {16'h0021, 16'h0021, 5'd0}) begin
          n_fail++; $display("FAIL reset_mid_accept: got %h/%h/%0d want 0021/0021/0", sw_state, sw_rise, sw_index);
        end
      end
      n_chk++;
      if (obs_all !== exp_all) begin n_fail++; $display("FAIL reset_mid_model: got %h want %h", obs_all, exp_all); end
    end
    n_chk++;
    if (hit != 6) begin n_fail++; $display("FAIL reset_mid_latency: got %0d want 6", hit); end
  endtask

  task automatic test_random;
    int hold;
    for (int s = 0; s < 120; s++) begin
      stswi = stswi ^ 16'($urandom & $urandom);
      ack = 16'($urandom);
      hold = $urandom_range(1, 7);
      for (int c = 0; c < hold; c++) begin
        @(negedge clk);
        n_chk++;
        if (obs_all !== exp_all) begin n_fail++; $display("FAIL random_model seg %0d: got %h want %h", s, obs_all, exp_all); end
      end
    end
    ack = '0;
  endtask

`ifdef SWI_STICKY_EN
  task automatic test_sticky;
    int hit;
    stswi = 16'h0;
    ack = '1;
    repeat (12) @(negedge clk);
    ack = '0;
    stswi = 16'h0008;
    hit = 0;
    for (int e = 1; e <= 10 && hit == 0; e++) begin
      @(negedge clk);
      if (sw_rise[3]) hit = e;
    end
    n_chk++;
    if (hit == 0) begin n_fail++; $display("FAIL sticky_rise_timeout: got none want rise"); end
    ack = 16'h0008;
    @(negedge clk);
    ack = '0;
    n_chk++;
    if (pend[3] !== 1'b1) begin n_fail++; $display("FAIL sticky_set_wins: got %b want 1", pend[3]); end
    repeat (2) @(negedge clk);
    ack = 16'h0008;
    @(negedge clk);
    ack = '0;
    n_chk++;
    if (pend[3] !== 1'b0) begin n_fail++; $display("FAIL sticky_ack_clear: got %b want 0", pend[3]); end
    n_chk++;
    if (obs_all !== exp_all) begin n_fail++; $display("FAIL sticky_model: got %h want %h", obs_all, exp_all); end
  endtask
`endif

  initial begin
    test_reset();
    test_glitch();
    test_step();
    test_multi();
    test_reset_mid();
    test_random();
`ifdef SWI_STICKY_EN
    test_sticky();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
